// File: rtl/sf_camera_sequencer.sv
// sf_camera_sequencer
//   Camera control sequencer sitting between the camera register file and
//   the camera PHY pins. It divides the system clock down to the camera input
//   clock, runs a timed reset/startup sequence, stages the reader/DMA/interrupt
//   enables once the camera is READY, and drives the flash in one of four modes.
//
//   Optional feature macro: SF_CAMERA_FLASH_TIMEOUT_EN
//     defined   : consecutive flash-on cycles are counted. Reaching
//                 FLASH_MAX_CYCLES forces the flash off and sets a sticky
//                 fault flag, which clears on flash mode 0 or a camera reset.
//     undefined : no timeout logic, o_flash_fault is tied to 0.
//
// Ports
//   clk                 system clock (only clock)
//   rst                 asynchronous active-low reset
//   i_camera_reset      level, forces the sequence back to RESET while high
//   i_enable            level, requests the capture-path enables
//   i_flash_mode[1:0]   0 off, 1 manual, 2 strobe-follow, 3 timed pulse
//   i_manual_flash_on   flash level in manual mode
//   i_flash_strobe      asynchronous camera strobe
//   o_cam_in_clk        divided camera input clock (CLK_DIV clk cycles/period)
//   o_cam_rst           camera reset, active high
//   o_flash             registered flash drive
//   o_clk_locked        divider has completed its first full period
//   o_ready             sequencer is in READY
//   o_state[1:0]        0 RESET, 1 STARTUP, 2 READY
//   o_enable_reader     first staged enable
//   o_enable_dma        second staged enable (one cycle after reader)
//   o_enable_interrupt  third staged enable (one cycle after dma)
//   o_flash_fault       sticky flash timeout flag

module sf_camera_sequencer #(
    parameter int unsigned CLK_DIV            = 4,
    parameter int unsigned RESET_CYCLES       = 64,
    parameter int unsigned STARTUP_CYCLES     = 1024,
    parameter int unsigned FLASH_PULSE_CYCLES = 256,
    parameter int unsigned FLASH_MAX_CYCLES   = 65535,
    parameter int unsigned CNT_WIDTH          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_camera_reset,
    input  logic       i_enable,
    input  logic [1:0] i_flash_mode,
    input  logic       i_manual_flash_on,
    input  logic       i_flash_strobe,
    output logic       o_cam_in_clk,
    output logic       o_cam_rst,
    output logic       o_flash,
    output logic       o_clk_locked,
    output logic       o_ready,
    output logic [1:0] o_state,
    output logic       o_enable_reader,
    output logic       o_enable_dma,
    output logic       o_enable_interrupt,
    output logic       o_flash_fault
);

    localparam int unsigned     HALF_DIV  = CLK_DIV / 2;
    localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_WIDTH;

    // Every cycle parameter has to fit the shared counter width.
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0 || RESET_CYCLES < 1 ||
        STARTUP_CYCLES < 1 || FLASH_PULSE_CYCLES < 1 ||
        longint'(RESET_CYCLES) >= CNT_LIMIT ||
        longint'(STARTUP_CYCLES) >= CNT_LIMIT ||
        longint'(FLASH_PULSE_CYCLES) >= CNT_LIMIT ||
        longint'(FLASH_MAX_CYCLES) >= CNT_LIMIT) begin : g_bad_config
        $error("sf_camera_sequencer: invalid parameter set");
    end

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_STARTUP = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] seq_cnt;
    logic [CNT_WIDTH-1:0] div_cnt;
    logic [CNT_WIDTH-1:0] pulse_cnt;
    logic [CNT_WIDTH-1:0] pulse_nxt;
    logic                 strobe_m;
    logic                 strobe_s;
    logic                 strobe_d;
    logic                 flash_raw;
    logic                 flash_nxt;
    logic                 active;

    // A camera reset request takes effect on the same edge, so enables and
    // flash must already be treated as inactive while it is sampled high.
    assign active  = (state == ST_READY) && !i_camera_reset;
    assign o_state = state;

    // Reset / startup sequencer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RESET;
            seq_cnt   <= '0;
            o_cam_rst <= 1'b1;
            o_ready   <= 1'b0;
        end else if (i_camera_reset) begin
            state     <= ST_RESET;
            seq_cnt   <= '0;
            o_cam_rst <= 1'b1;
            o_ready   <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    if (seq_cnt == CNT_WIDTH'(RESET_CYCLES - 1)) begin
                        state     <= ST_STARTUP;
                        seq_cnt   <= '0;
                        o_cam_rst <= 1'b0;
                    end else begin
                        seq_cnt <= seq_cnt + 1'b1;
                    end
                end
                ST_STARTUP: begin
                    if (seq_cnt == CNT_WIDTH'(STARTUP_CYCLES - 1)) begin
                        state   <= ST_READY;
                        seq_cnt <= '0;
                        o_ready <= 1'b1;
                    end else begin
                        seq_cnt <= seq_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                end
                default: begin
                    state     <= ST_RESET;
                    seq_cnt   <= '0;
                    o_cam_rst <= 1'b1;
                    o_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Camera clock divider; free-running in every sequencer state.
    // Lock is declared on the falling toggle that closes the first period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt      <= '0;
            o_cam_in_clk <= 1'b0;
            o_clk_locked <= 1'b0;
        end else if (div_cnt == CNT_WIDTH'(HALF_DIV - 1)) begin
            div_cnt      <= '0;
            o_cam_in_clk <= ~o_cam_in_clk;
            if (o_cam_in_clk) begin
                o_clk_locked <= 1'b1;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Staged capture enables: reader, then dma, then interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_enable_reader    <= 1'b0;
            o_enable_dma       <= 1'b0;
            o_enable_interrupt <= 1'b0;
        end else if (!active || !i_enable) begin
            o_enable_reader    <= 1'b0;
            o_enable_dma       <= 1'b0;
            o_enable_interrupt <= 1'b0;
        end else begin
            o_enable_reader    <= 1'b1;
            o_enable_dma       <= o_enable_reader;
            o_enable_interrupt <= o_enable_dma;
        end
    end

    // Strobe synchroniser plus one extra stage for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strobe_m <= 1'b0;
            strobe_s <= 1'b0;
            strobe_d <= 1'b0;
        end else begin
            strobe_m <= i_flash_strobe;
            strobe_s <= strobe_m;
            strobe_d <= strobe_s;
        end
    end

    // Flash mode decode. In timed mode pulse_cnt holds the number of edges the
    // pulse still owns; the final edge (count 1) drops the flash and also
    // swallows any strobe edge seen there, since the pulse is still running.
    // Any mode other than 3, or leaving READY, clears the pulse.
    always_comb begin
        flash_raw = 1'b0;
        pulse_nxt = '0;
        if (active) begin
            case (i_flash_mode)
                2'd1: flash_raw = i_manual_flash_on;
                2'd2: flash_raw = strobe_s;
                2'd3: begin
                    if (pulse_cnt != '0) begin
                        flash_raw = (pulse_cnt != CNT_WIDTH'(1));
                        pulse_nxt = pulse_cnt - 1'b1;
                    end else if (strobe_s && !strobe_d) begin
                        flash_raw = 1'b1;
                        pulse_nxt = CNT_WIDTH'(FLASH_PULSE_CYCLES);
                    end
                end
                default: flash_raw = 1'b0;
            endcase
        end
    end

`ifdef SF_CAMERA_FLASH_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] on_cnt;
    logic                 flash_ok;
    logic                 trip;

    // on_cnt is the number of consecutive cycles o_flash has already been high
    assign flash_ok  = flash_raw && !o_flash_fault;
    assign trip      = flash_ok && (on_cnt == CNT_WIDTH'(FLASH_MAX_CYCLES));
    assign flash_nxt = flash_ok && !trip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            on_cnt        <= '0;
            o_flash_fault <= 1'b0;
        end else begin
            on_cnt <= flash_nxt ? on_cnt + 1'b1 : '0;
            if (i_flash_mode == 2'd0 || i_camera_reset) begin
                o_flash_fault <= 1'b0;
            end else if (trip) begin
                o_flash_fault <= 1'b1;
            end
        end
    end
`else
    assign flash_nxt     = flash_raw;
    assign o_flash_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_flash   <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            o_flash   <= flash_nxt;
            pulse_cnt <= pulse_nxt;
        end
    end

endmodule

// File: tb/tb_sf_camera_sequencer.sv
module tb_sf_camera_sequencer;

    localparam int CLK_DIV            = 4;
    localparam int RESET_CYCLES       = 8;
    localparam int STARTUP_CYCLES     = 16;
    localparam int FLASH_PULSE_CYCLES = 10;
    localparam int FLASH_MAX_CYCLES   = 20;
    localparam int CNT_WIDTH          = 16;

    // {state, cam_rst, ready, cam_in_clk, locked, reader, dma, intr, flash, fault}
    localparam logic [10:0] RESET_VEC = {2'b00, 1'b1, 8'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_camera_reset = 1'b0;
    logic       i_enable = 1'b0;
    logic [1:0] i_flash_mode = 2'd0;
    logic       i_manual_flash_on = 1'b0;
    logic       i_flash_strobe = 1'b0;
    logic       o_cam_in_clk, o_cam_rst, o_flash, o_clk_locked, o_ready;
    logic [1:0] o_state;
    logic       o_enable_reader, o_enable_dma, o_enable_interrupt, o_flash_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sf_camera_sequencer #(
        .CLK_DIV(CLK_DIV),
        .RESET_CYCLES(RESET_CYCLES),
        .STARTUP_CYCLES(STARTUP_CYCLES),
        .FLASH_PULSE_CYCLES(FLASH_PULSE_CYCLES),
        .FLASH_MAX_CYCLES(FLASH_MAX_CYCLES),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_camera_reset(i_camera_reset),
        .i_enable(i_enable),
        .i_flash_mode(i_flash_mode),
        .i_manual_flash_on(i_manual_flash_on),
        .i_flash_strobe(i_flash_strobe),
        .o_cam_in_clk(o_cam_in_clk),
        .o_cam_rst(o_cam_rst),
        .o_flash(o_flash),
        .o_clk_locked(o_clk_locked),
        .o_ready(o_ready),
        .o_state(o_state),
        .o_enable_reader(o_enable_reader),
        .o_enable_dma(o_enable_dma),
        .o_enable_interrupt(o_enable_interrupt),
        .o_flash_fault(o_flash_fault)
    );

    // ---------------- reference model ----------------
    // Time-based: edges since rst release, sequence age since the last camera
    // reset, run length of the enable request, and the edge a pulse began at.
    int     m_n;
    int     m_age;
    int     m_state;
    int     m_en_run;
    int     m_hi_run;
    longint m_pulse_start;
    bit     m_flash;
    bit     m_fault;
    bit     m_samp[int];

    function automatic bit samp_at(int k);
        if (k < 1 || !m_samp.exists(k)) return 1'b0;
        return m_samp[k];
    endfunction

    function automatic logic [10:0] model_vec();
        logic [1:0] st;
        bit ck;
        st = 2'(m_state);
        ck = ((m_n / (CLK_DIV / 2)) % 2) == 1;
        return {st, m_state == 0, m_state == 2, ck, m_n >= CLK_DIV,
                m_en_run >= 1, m_en_run >= 2, m_en_run >= 3, m_flash, m_fault};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {o_state, o_cam_rst, o_ready, o_cam_in_clk, o_clk_locked,
                o_enable_reader, o_enable_dma, o_enable_interrupt, o_flash, o_flash_fault};
    endfunction

    task automatic model_reset();
        m_n = 0; m_age = 0; m_state = 0; m_en_run = 0; m_hi_run = 0;
        m_pulse_start = -1000000; m_flash = 1'b0; m_fault = 1'b0;
        m_samp.delete();
    endtask

    task automatic model_edge();
        bit go, raw, rise;
`ifdef SF_CAMERA_FLASH_TIMEOUT_EN
        bit trip, clr;
`endif
        go = (m_state == 2) && !i_camera_reset;
        m_n++;
        m_samp[m_n] = i_flash_strobe;
        if (i_camera_reset) m_age = 0;
        else if (m_age < RESET_CYCLES + STARTUP_CYCLES) m_age++;
        if (i_camera_reset || m_age < RESET_CYCLES) m_state = 0;
        else if (m_age < RESET_CYCLES + STARTUP_CYCLES) m_state = 1;
        else m_state = 2;
        m_en_run = (go && i_enable) ? ((m_en_run < 3) ? m_en_run + 1 : 3) : 0;
        rise = samp_at(m_n - 2) && !samp_at(m_n - 3);
        raw = 1'b0;
        if (!go || i_flash_mode != 2'd3) m_pulse_start = -1000000;
        if (go) begin
            case (i_flash_mode)
                2'd1: raw = i_manual_flash_on;
                2'd2: raw = samp_at(m_n - 2);
                2'd3: begin
                    if (rise && (m_n - m_pulse_start) > FLASH_PULSE_CYCLES) m_pulse_start = m_n;
                    raw = (m_n - m_pulse_start) < FLASH_PULSE_CYCLES;
                end
                default: raw = 1'b0;
            endcase
        end
`ifdef SF_CAMERA_FLASH_TIMEOUT_EN
        trip     = raw && !m_fault && (m_hi_run == FLASH_MAX_CYCLES);
        m_flash  = raw && !m_fault && !trip;
        clr      = (i_flash_mode == 2'd0) || i_camera_reset;
        m_fault  = clr ? 1'b0 : (m_fault || trip);
        m_hi_run = m_flash ? m_hi_run + 1 : 0;
`else
        m_flash = raw;
        m_fault = 1'b0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        #22;
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", dut_vec(), RESET_VEC);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", dut_vec(), RESET_VEC);
        end
        rst = 1'b1;
    endtask

    task automatic test_powerup();
        logic [3:0] exp;
        for (int c = 1; c <= RESET_CYCLES + STARTUP_CYCLES; c++) begin
            step();
            exp = {c < RESET_CYCLES, c >= RESET_CYCLES + STARTUP_CYCLES,
                   ((c / 2) % 2) == 1, c >= CLK_DIV};
            checks++;
            if ({o_cam_rst, o_ready, o_cam_in_clk, o_clk_locked} !== exp) begin
                errors++;
                $display("FAIL powerup cycle %0d: got %b expected %b (rst,ready,clk,lock)",
                         c, {o_cam_rst, o_ready, o_cam_in_clk, o_clk_locked}, exp);
            end
        end
        checks++;
        if (o_state !== 2'd2) begin
            errors++;
            $display("FAIL powerup_state: got %0d expected 2", o_state);
        end
    endtask

    task automatic test_enable_staging();
        logic [2:0] exp_seq [9];
        logic       en_seq [9];
        en_seq  = '{1, 1, 1, 0, 1, 0, 1, 1, 1};
        exp_seq = '{3'b100, 3'b110, 3'b111, 3'b000, 3'b100, 3'b000, 3'b100, 3'b110, 3'b111};
        for (int k = 0; k < 9; k++) begin
            i_enable = en_seq[k];
            step();
            checks++;
            if ({o_enable_reader, o_enable_dma, o_enable_interrupt} !== exp_seq[k]) begin
                errors++;
                $display("FAIL enable_stage %0d: got %b expected %b", k,
                         {o_enable_reader, o_enable_dma, o_enable_interrupt}, exp_seq[k]);
            end
        end
    endtask

    task automatic test_camera_reset();
        int fall_at;
        int ready_at;
        i_flash_mode = 2'd1;
        i_manual_flash_on = 1'b1;
        step();
        checks++;
        if ({o_flash, o_enable_interrupt} !== 2'b11) begin
            errors++;
            $display("FAIL camreset_pre: got %b expected 11 (flash,intr)", {o_flash, o_enable_interrupt});
        end
        i_camera_reset = 1'b1;
        step();
        checks++;
        if ({o_cam_rst, o_flash, o_enable_reader, o_enable_dma, o_enable_interrupt, o_state} !== 7'b1000000) begin
            errors++;
            $display("FAIL camreset_entry: got %b expected 1000000",
                     {o_cam_rst, o_flash, o_enable_reader, o_enable_dma, o_enable_interrupt, o_state});
        end
        repeat (4) step();
        i_camera_reset = 1'b0;
        fall_at = -1;
        for (int k = 1; k <= 4 * RESET_CYCLES; k++) begin
            step();
            if (!o_cam_rst) begin
                fall_at = k;
                break;
            end
        end
        checks++;
        if (fall_at != RESET_CYCLES) begin
            errors++;
            $display("FAIL camreset_release: got %0d expected %0d cycles", fall_at, RESET_CYCLES);
        end
        ready_at = -1;
        for (int k = 1; k <= 4 * STARTUP_CYCLES; k++) begin
            step();
            if (o_ready) begin
                ready_at = k;
                break;
            end
        end
        checks++;
        if (ready_at != STARTUP_CYCLES) begin
            errors++;
            $display("FAIL camreset_restart: got %0d expected %0d cycles", ready_at, STARTUP_CYCLES);
        end
        step();
        checks++;
        if ({o_enable_reader, o_enable_dma, o_flash} !== 3'b101) begin
            errors++;
            $display("FAIL camreset_resume: got %b expected 101 (reader,dma,flash)",
                     {o_enable_reader, o_enable_dma, o_flash});
        end
        i_manual_flash_on = 1'b0;
        i_flash_mode = 2'd0;
        step();
    endtask

    task automatic test_flash_follow();
        logic exp_seq [4];
        exp_seq = '{0, 0, 1, 1};
        i_flash_mode = 2'd2;
        i_flash_strobe = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (o_flash !== exp_seq[k]) begin
                errors++;
                $display("FAIL strobe_follow %0d: got %b expected %b", k, o_flash, exp_seq[k]);
            end
        end
        i_flash_strobe = 1'b0;
        repeat (3) step();
        i_flash_mode = 2'd0;
        step();
    endtask

    task automatic test_flash_pulse();
        logic exp;
        int   high_cnt;
        i_flash_mode = 2'd3;
        i_flash_strobe = 1'b0;
        repeat (3) step();
        high_cnt = 0;
        for (int j = 1; j <= 20; j++) begin
            i_flash_strobe = (j == 1) || (j == 5);
            step();
            exp = (j >= 3) && (j < 3 + FLASH_PULSE_CYCLES);
            if (o_flash) high_cnt++;
            checks++;
            if (o_flash !== exp) begin
                errors++;
                $display("FAIL pulse cycle %0d: got %b expected %b", j, o_flash, exp);
            end
        end
        checks++;
        if (high_cnt != FLASH_PULSE_CYCLES) begin
            errors++;
            $display("FAIL pulse_length: got %0d expected %0d", high_cnt, FLASH_PULSE_CYCLES);
        end
        // a mode change mid-pulse drops the flash on the next edge
        i_flash_strobe = 1'b1;
        repeat (4) step();
        i_flash_mode = 2'd0;
        step();
        checks++;
        if (o_flash !== 1'b0) begin
            errors++;
            $display("FAIL pulse_abort: got %b expected 0", o_flash);
        end
        i_flash_strobe = 1'b0;
        repeat (3) step();
    endtask

`ifdef SF_CAMERA_FLASH_TIMEOUT_EN
    task automatic test_flash_timeout();
        int high_cnt;
        i_flash_mode = 2'd1;
        i_manual_flash_on = 1'b1;
        high_cnt = 0;
        for (int k = 0; k < 2 * FLASH_MAX_CYCLES; k++) begin
            step();
            if (o_flash) high_cnt++;
        end
        checks++;
        if ({high_cnt, o_flash, o_flash_fault} !== {32'(FLASH_MAX_CYCLES), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL timeout: got high=%0d flash=%b fault=%b expected high=%0d flash=0 fault=1",
                     high_cnt, o_flash, o_flash_fault, FLASH_MAX_CYCLES);
        end
        i_flash_mode = 2'd0;
        i_manual_flash_on = 1'b0;
        step();
        checks++;
        if (o_flash_fault !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b expected 0", o_flash_fault);
        end
    endtask
`endif

    task automatic test_model_sync();
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL model_sync: got %b expected %b", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int k = 0; k < 3000; k++) begin
            if (hold > 0) begin
                hold--;
                i_camera_reset = (hold != 0);
            end else if ($urandom_range(199) == 0) begin
                hold = $urandom_range(6, 1);
                i_camera_reset = 1'b1;
            end
            if ($urandom_range(15) == 0) i_enable = ~i_enable;
            if ($urandom_range(39) == 0) i_flash_mode = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) i_manual_flash_on = ~i_manual_flash_on;
            if ($urandom_range(5) == 0) i_flash_strobe = ~i_flash_strobe;
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %b expected %b", k, dut_vec(), model_vec());
            end
        end
        i_camera_reset = 1'b0;
    endtask

    task automatic test_async_reset();
        int wait_cnt;
        i_camera_reset = 1'b1;
        step();
        i_camera_reset = 1'b0;
        wait_cnt = 0;
        while (o_state != 2'd1 && wait_cnt < 4 * RESET_CYCLES) begin
            step();
            wait_cnt++;
        end
        checks++;
        if (o_state !== 2'd1) begin
            errors++;
            $display("FAIL async_setup: got state %0d expected 1", o_state);
        end
        i_flash_mode = 2'd2;
        i_flash_strobe = 1'b1;
        i_enable = 1'b1;
        repeat (3) step();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", dut_vec(), RESET_VEC);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset_hold: got %b expected %b", dut_vec(), RESET_VEC);
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_enable_staging();
        test_camera_reset();
        test_flash_follow();
        test_flash_pulse();
`ifdef SF_CAMERA_FLASH_TIMEOUT_EN
        test_flash_timeout();
`endif
        test_model_sync();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sf_camera_sequencer.md
# sf_camera_sequencer

Parametrised camera control sequencer between the camera register file and the camera PHY pins. Generates the camera input clock with an integer divider and runs a timed camera reset/startup sequence. Stages the DMA, reader and interrupt enables, and drives the flash in one of four modes with an optional safety timeout. It replaces the free-running clock generator and the combinational flash/reset pass-through of the previous controller.

## Interface
- CLK_DIV, 4: clk cycles per o_cam_in_clk period; even, ≥2.
- RESET_CYCLES, 64: cycles o_cam_rst is held high per reset sequence; ≥1.
- STARTUP_CYCLES, 1024: cycles after o_cam_rst release before READY; ≥1.
- FLASH_PULSE_CYCLES, 256: pulse length in timed-flash mode; ≥1.
- FLASH_MAX_CYCLES, 65535: safety-timeout limit; used only with the macro.
- CNT_WIDTH, 16: width of the shared sequence counter and flash counters; must hold every cycle parameter.
- clk  in  1  system clock; only clock.
- rst  in  1  asynchronous, active-low reset.
- i_camera_reset  in  1  level; high forces the sequence back to RESET.
- i_enable  in  1  level; requests capture-path enables.
- i_flash_mode  in  2  0 off, 1 manual, 2 strobe-follow, 3 timed pulse.
- i_manual_flash_on  in  1  flash level in mode 1.
- i_flash_strobe  in  1  asynchronous camera strobe.
- o_cam_in_clk  out  1  divided camera input clock.
- o_cam_rst  out  1  camera reset, active high.
- o_flash  out  1  registered flash drive.
- o_clk_locked  out  1  high once the divider has completed one full period after reset.
- o_ready  out  1  sequencer in READY.
- o_state  out  2  0 RESET, 1 STARTUP, 2 READY.
- o_enable_reader, o_enable_dma, o_enable_interrupt  out  1 each  staged capture enables.
- o_flash_fault  out  1  sticky timeout flag; constant 0 without the macro.

## Operation
- State machine:
  - RESET: o_cam_rst=1; counter counts to RESET_CYCLES-1, then goes to STARTUP with the counter cleared.
  - STARTUP: o_cam_rst=0; counter counts to STARTUP_CYCLES-1, then goes to READY.
  - READY: holds until i_camera_reset is high.
  - i_camera_reset high in any state: go to RESET with counter=0; stay there while it is held; the count starts after it drops.
- Divider: toggles o_cam_in_clk every CLK_DIV/2 cycles in all states; 50% duty cycle.
- Enables:
  - Active only in READY.
  - On i_enable high: o_enable_reader rises, o_enable_dma one cycle later, o_enable_interrupt one cycle after that.
  - i_enable low, or leaving READY: all three drop on the same edge.
  - i_enable re-asserted mid-staging: staging restarts from reader.
- Flash:
  - i_flash_strobe passes through a 2-flop synchroniser (strobe_s).
  - o_flash is forced 0 outside READY.
  - Mode 0: o_flash=0.
  - Mode 1: o_flash=i_manual_flash_on.
  - Mode 2: o_flash=strobe_s.
  - Mode 3: a strobe_s rising edge loads the pulse counter; o_flash stays high for FLASH_PULSE_CYCLES cycles. Edges during a pulse are ignored.
  - Changing mode aborts any pulse; the new mode applies the next cycle.

## Timing
- Values on rst low: state RESET, counter 0, o_cam_rst 1, o_cam_in_clk 0, o_clk_locked 0, o_flash 0, o_flash_fault 0, all enables 0, o_ready 0.
- First rising edge of o_cam_in_clk comes CLK_DIV/2 cycles after rst release. o_clk_locked rises at the end of the first full period (CLK_DIV cycles) and stays high until rst.
- rst release to o_cam_rst fall: RESET_CYCLES cycles. To o_ready high: RESET_CYCLES+STARTUP_CYCLES cycles.
- All outputs are registered. i_enable to o_enable_reader: 1 cycle; o_enable_interrupt at cycle 3.
- i_flash_strobe to o_flash: 3 cycles (2 sync + output register) in modes 2 and 3.
- i_manual_flash_on to o_flash: 1 cycle.
- i_camera_reset to o_cam_rst high, and to enables/flash low: 1 cycle.
- rst asserted mid-sequence or mid-pulse: immediate asynchronous return to reset values.

## Configuration
- SF_CAMERA_FLASH_TIMEOUT_EN defined:
  - A counter tracks consecutive o_flash-high cycles.
  - When it reaches FLASH_MAX_CYCLES, o_flash is forced 0 and o_flash_fault is set.
  - While o_flash_fault is high, o_flash stays 0.
  - o_flash_fault clears when i_flash_mode=0 or i_camera_reset is high.
- SF_CAMERA_FLASH_TIMEOUT_EN undefined: no timeout counter; o_flash_fault tied 0; flash may stay high indefinitely.

## Test plan
- Power-up, CLK_DIV=4, RESET_CYCLES=8, STARTUP_CYCLES=16: release rst -> o_cam_rst falls at cycle 8, o_ready rises at cycle 24, o_cam_in_clk period 4, o_clk_locked high at cycle 4.
- In READY, raise i_enable -> reader/dma/interrupt rise at cycles 1/2/3. Drop i_enable -> all three low 1 cycle later.
- Pulse i_camera_reset for 5 cycles while enabled with mode 1 flash on -> enables and o_flash low after 1 cycle, o_cam_rst high for 5+RESET_CYCLES cycles, then full restart.
- Mode 3, FLASH_PULSE_CYCLES=10, strobe pulses at t=0 and t=4 -> o_flash high cycles 3..12 exactly once; second edge ignored.
- With macro, FLASH_MAX_CYCLES=20, mode 1 held on -> o_flash low after 20 high cycles, o_flash_fault=1. Write mode 0 -> fault clears.
- Assert rst mid-STARTUP with mode 2 strobe high -> all outputs at reset values immediately, without waiting for a clk edge.
